reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port integer register file; successor to the single-write/dual-read file.
//  Adds N read ports, M write ports, a write-to-read bypass and a per-register busy scoreboard.
//  The scoreboard lets the multi-cycle core stall on operands whose producer has not written back.
//  Sits between decode (reads, allocation) and writeback (writes); x0 is hardwired to zero.
// PARAMETERS
//  REGISTER_COUNT   32  number of architectural registers; power of two, >= 2
//  REGISTER_WIDTH   32  data width in bits
//  REG_INDEX_WIDTH   5  = $clog2(REGISTER_COUNT)
//  NUM_RD_PORTS      2  read ports, 1..4
//  NUM_WR_PORTS      1  write ports, 1..2
//  BYPASS            1  1 = same-cycle write data forwarded to matching reads; 0 = read returns stored value
// PORTS
//  clk        in   1                              clock, rising edge
//  rst        in   1                              asynchronous, active-low reset
//  rd_idx     in   NUM_RD_PORTS*REG_INDEX_WIDTH   read indices; port p = bits [p*IW +: IW]
//  rd_data    out  NUM_RD_PORTS*REGISTER_WIDTH    read data, combinational
//  rd_busy    out  NUM_RD_PORTS                   1 = register at rd_idx[p] awaits a write
//  wr_en      in   NUM_WR_PORTS                   write strobe per port
//  wr_idx     in   NUM_WR_PORTS*REG_INDEX_WIDTH   write indices
//  wr_data    in   NUM_WR_PORTS*REGISTER_WIDTH    write data
//  alloc_en   in   1                              mark alloc_idx busy (issue of a producing instruction)
//  alloc_idx  in   REG_INDEX_WIDTH                register being allocated
//  busy_vec   out  REGISTER_COUNT                 registered scoreboard; bit 0 is always 0
// BEHAVIOUR
//  Reset (rst=0, async): all registers cleared to 0, busy_vec = 0.
//   Consequently rd_data = 0 and rd_busy = 0 while reset is held.
//  Reads: combinational, zero latency.
//   rd_idx=0 -> rd_data=0 and rd_busy=0, unconditionally.
//  Writes: at posedge clk when wr_en[w]=1 and wr_idx[w]!=0, reg[wr_idx[w]] <= wr_data[w]. Writes to x0 are dropped.
//   Two write ports targeting the same index in one cycle: the higher port index wins.
//   Neither write is an error.
//  Bypass (BYPASS=1): if any wr_en[w] with wr_idx[w]==rd_idx[p]!=0, rd_data[p] = wr_data of the winning port.
//   rd_busy[p] = 0 for that port that cycle, unless the same index is also being allocated (alloc wins, below).
//   With BYPASS=0 the stored value and busy bit are returned until the next edge.
//  Scoreboard, evaluated at posedge clk per register r != 0, in priority order:
//   1. alloc_en & alloc_idx==r      -> busy[r] <= 1 (a new producer overrides the completing write)
//   2. any wr_en[w] & wr_idx[w]==r  -> busy[r] <= 0
//   3. otherwise busy[r] holds.
//   A write to a non-busy register is legal and leaves busy at 0.
//   alloc_idx=0 is ignored.
//  busy_vec is flop outputs only.
//   rd_busy[p] = busy[rd_idx[p]], optionally cleared by bypass as above.
//  Reset asserted mid-operation clears state immediately; in-flight writes and allocs that cycle are lost.
//  No X propagation: unused index bits (REGISTER_COUNT < 2^IW impossible by parameter rule) need no handling.
// STRUCTURE
//  reg_file_pkg: REGISTER_COUNT/WIDTH/REG_INDEX_WIDTH defaults, the x0 index constant,
//   and a function for the write-port priority select.
//  Sub-module reg_file_rd_port, one instance per read port via generate.
//   It takes the array slice, busy_vec, and all write ports, and produces rd_data[p] and rd_busy[p].
//   It holds the x0, bypass and priority logic.
//  Top level owns the storage array, the write decode and the scoreboard flops.
// TESTING
//  1 Reset: drive rst=0 then 1, read idx 10 and 15 -> rd_data=0, rd_busy=0, busy_vec=0.
//  2 Write/readback: wr_idx=5, wr_data=1234, one cycle; next cycle rd_idx=5 -> 1234.
//    Same cycle with BYPASS=1 -> rd_data=1234 immediately.
//  3 x0: write 2431 to idx 0, then alloc idx 0 -> rd_data[idx0]=0, busy_vec[0]=0.
//  4 Scoreboard: alloc idx 7 -> busy_vec[7]=1 and rd_busy=1 at idx 7.
//    Then write 99 to idx 7 -> busy_vec[7]=0, read returns 99.
//  5 Collision, M=2: both ports write idx 3 (port0 = 11, port1 = 22) -> reg3=22.
//    In the same cycle, alloc idx 3 plus a write to idx 3 -> busy_vec[3]=1, data=22.
//  6 Mid-op reset: busy 7, reg 5=1234; pulse rst low mid-cycle -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Holds the x0 index constant and the write-port priority select.
package reg_file_pkg;

  localparam int DEF_REGISTER_COUNT  = 32;
  localparam int DEF_REGISTER_WIDTH  = 32;
  localparam int DEF_REG_INDEX_WIDTH = 5;
  localparam int MAX_WR_PORTS        = 2;
  localparam int WR_SEL_W            = 1;
  localparam int X0_IDX              = 0;

  // Highest-numbered matching write port wins a same-index collision.
  function automatic logic [WR_SEL_W-1:0] wr_prio_sel(input logic [MAX_WR_PORTS-1:0] match);
    logic [WR_SEL_W-1:0] sel;
    sel = '0;
    for (int w = 0; w < MAX_WR_PORTS; w++) begin
      if (match[w]) sel = WR_SEL_W'(w);
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: stored value, x0 forcing and write bypass.
// Write strobes arriving here are already gated off while reset is held.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int REGISTER_COUNT  = DEF_REGISTER_COUNT,
  parameter int REGISTER_WIDTH  = DEF_REGISTER_WIDTH,
  parameter int REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH,
  parameter int NUM_WR_PORTS    = 1,
  parameter int BYPASS          = 1
) (
  input  logic [REG_INDEX_WIDTH-1:0]              rd_idx_i,
  input  logic [REGISTER_WIDTH-1:0]               stored_i,
  input  logic [REGISTER_COUNT-1:0]               busy_vec_i,
  input  logic [NUM_WR_PORTS-1:0]                 wr_en_i,
  input  logic [NUM_WR_PORTS*REG_INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [NUM_WR_PORTS*REGISTER_WIDTH-1:0]  wr_data_i,
  input  logic                                    alloc_en_i,
  input  logic [REG_INDEX_WIDTH-1:0]              alloc_idx_i,
  output logic [REGISTER_WIDTH-1:0]               rd_data_o,
  output logic                                    rd_busy_o
);

  logic [NUM_WR_PORTS-1:0] match;
  logic [MAX_WR_PORTS-1:0] match_pad;
  logic [WR_SEL_W-1:0]     sel;
  logic                    is_x0;
  logic                    hit;

  always_comb begin
    match = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      match[w] = wr_en_i[w] && (wr_idx_i[w*REG_INDEX_WIDTH +: REG_INDEX_WIDTH] == rd_idx_i);
    end
    match_pad = '0;
    match_pad[NUM_WR_PORTS-1:0] = match;
    sel   = wr_prio_sel(match_pad);
    is_x0 = (rd_idx_i == REG_INDEX_WIDTH'(X0_IDX));
    hit   = (BYPASS != 0) && (|match) && !is_x0;

    rd_data_o = stored_i;
    rd_busy_o = busy_vec_i[rd_idx_i];
    if (hit) begin
      rd_data_o = wr_data_i[int'(sel)*REGISTER_WIDTH +: REGISTER_WIDTH];
      // A same-cycle allocation re-arms the register, so the write does not clear busy.
      if (!(alloc_en_i && (alloc_idx_i == rd_idx_i))) rd_busy_o = 1'b0;
    end
    if (is_x0) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write bypass and busy scoreboard.
// Owns storage, write decode and scoreboard flops; reads are per-port instances.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int REGISTER_COUNT  = DEF_REGISTER_COUNT,
  parameter int REGISTER_WIDTH  = DEF_REGISTER_WIDTH,
  parameter int REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH,
  parameter int NUM_RD_PORTS    = 2,
  parameter int NUM_WR_PORTS    = 1,
  parameter int BYPASS          = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_RD_PORTS*REG_INDEX_WIDTH-1:0] rd_idx,
  output logic [NUM_RD_PORTS*REGISTER_WIDTH-1:0]  rd_data,
  output logic [NUM_RD_PORTS-1:0]                 rd_busy,
  input  logic [NUM_WR_PORTS-1:0]                 wr_en,
  input  logic [NUM_WR_PORTS*REG_INDEX_WIDTH-1:0] wr_idx,
  input  logic [NUM_WR_PORTS*REGISTER_WIDTH-1:0]  wr_data,
  input  logic                                    alloc_en,
  input  logic [REG_INDEX_WIDTH-1:0]              alloc_idx,
  output logic [REGISTER_COUNT-1:0]               busy_vec
);

  logic [REGISTER_WIDTH-1:0] regs_q [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0] busy_q, busy_d;
  logic [NUM_WR_PORTS-1:0]   wr_en_live;

  // Bypass must not leak write data onto the read ports while reset is held.
  assign wr_en_live = rst ? wr_en : '0;
  assign busy_vec   = busy_q;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en[w]) busy_d[wr_idx[w*REG_INDEX_WIDTH +: REG_INDEX_WIDTH]] = 1'b0;
    end
    if (alloc_en) busy_d[alloc_idx] = 1'b1;
    busy_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REGISTER_COUNT; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      // Ascending loop order makes the higher write port win a collision.
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_en[w] && (wr_idx[w*REG_INDEX_WIDTH +: REG_INDEX_WIDTH] != REG_INDEX_WIDTH'(X0_IDX)))
          regs_q[wr_idx[w*REG_INDEX_WIDTH +: REG_INDEX_WIDTH]] <= wr_data[w*REGISTER_WIDTH +: REGISTER_WIDTH];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [REG_INDEX_WIDTH-1:0] idx;
    assign idx = rd_idx[p*REG_INDEX_WIDTH +: REG_INDEX_WIDTH];

    reg_file_rd_port #(
      .REGISTER_COUNT (REGISTER_COUNT),
      .REGISTER_WIDTH (REGISTER_WIDTH),
      .REG_INDEX_WIDTH(REG_INDEX_WIDTH),
      .NUM_WR_PORTS   (NUM_WR_PORTS),
      .BYPASS         (BYPASS)
    ) u_rd (
      .rd_idx_i   (idx),
      .stored_i   (regs_q[idx]),
      .busy_vec_i (busy_q),
      .wr_en_i    (wr_en_live),
      .wr_idx_i   (wr_idx),
      .wr_data_i  (wr_data),
      .alloc_en_i (alloc_en),
      .alloc_idx_i(alloc_idx),
      .rd_data_o  (rd_data[p*REGISTER_WIDTH +: REGISTER_WIDTH]),
      .rd_busy_o  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed plus randomized bench for reg_file_mp (2 read, 2 write ports, bypass on).
// Expected values come from an array model updated with the architectural write/alloc rules.
module tb_reg_file_mp;

  localparam int RC = 32;
  localparam int RW = 32;
  localparam int IW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*IW-1:0] rd_idx = '0;
  logic [NR*RW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en = '0;
  logic [NW*IW-1:0] wr_idx = '0;
  logic [NW*RW-1:0] wr_data = '0;
  logic             alloc_en = 1'b0;
  logic [IW-1:0]    alloc_idx = '0;
  logic [RC-1:0]    busy_vec;

  int tests = 0;
  int fails = 0;

  logic [RW-1:0] m_reg  [RC];
  logic          m_busy [RC];

  reg_file_mp #(
    .REGISTER_COUNT(RC), .REGISTER_WIDTH(RW), .REG_INDEX_WIDTH(IW),
    .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < RC; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge, taken straight from the write/scoreboard rules.
  task automatic model_edge();
    for (int w = 0; w < NW; w++) begin
      int i;
      i = int'(wr_idx[w*IW +: IW]);
      if (wr_en[w] && i != 0) m_reg[i] = wr_data[w*RW +: RW];
      if (wr_en[w] && i != 0) m_busy[i] = 1'b0;
    end
    if (alloc_en && alloc_idx != 0) m_busy[int'(alloc_idx)] = 1'b1;
  endtask

  task automatic drive(input int r0, input int r1, input logic [1:0] we,
                       input int w0, input logic [RW-1:0] d0,
                       input int w1, input logic [RW-1:0] d1,
                       input logic ae, input int ai);
    rd_idx    = {IW'(r1), IW'(r0)};
    wr_en     = we;
    wr_idx    = {IW'(w1), IW'(w0)};
    wr_data   = {d1, d0};
    alloc_en  = ae;
    alloc_idx = IW'(ai);
  endtask

  task automatic check_outputs(input string tag);
    logic [RC-1:0] exp_vec;
    for (int p = 0; p < NR; p++) begin
      int            idx;
      logic [RW-1:0] ed;
      logic          eb;
      logic          hit;
      idx = int'(rd_idx[p*IW +: IW]);
      ed  = m_reg[idx];
      eb  = m_busy[idx];
      hit = 1'b0;
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && int'(wr_idx[w*IW +: IW]) == idx) begin
          ed  = wr_data[w*RW +: RW];
          hit = 1'b1;
        end
      end
      if (hit && !(alloc_en && int'(alloc_idx) == idx)) eb = 1'b0;
      if (idx == 0 || !rst) begin
        ed = '0;
        eb = 1'b0;
      end
      check($sformatf("%s_data%0d", tag, p), rd_data[p*RW +: RW], ed);
      check($sformatf("%s_busy%0d", tag, p), RW'(rd_busy[p]), RW'(eb));
    end
    for (int r = 0; r < RC; r++) exp_vec[r] = m_busy[r];
    check($sformatf("%s_busyvec", tag), RW'(busy_vec), RW'(exp_vec));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #2;
    check_outputs(tag);
    cycle();
  endtask

  initial begin
    model_clear();
    // Reset held
    drive(10, 15, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    #2;
    check_outputs("rst_held");
    @(negedge clk);
    rst = 1'b1;
    step("rst_rel");

    // Write/readback with same-cycle bypass
    drive(5, 0, 2'b01, 5, 32'd1234, 0, 0, 1'b0, 0);
    #2;
    check("wr_bypass", rd_data[RW-1:0], 32'd1234);
    step("wr5");
    drive(5, 6, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    #2;
    check("wr_readback", rd_data[RW-1:0], 32'd1234);
    step("rd5");

    // x0 stays zero and never busy
    drive(0, 5, 2'b01, 0, 32'd2431, 0, 0, 1'b0, 0);
    step("x0_wr");
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1'b1, 0);
    step("x0_alloc");
    #2;
    check("x0_data", rd_data[RW-1:0], 32'd0);
    check("x0_busyvec0", RW'(busy_vec[0]), 32'd0);

    // Scoreboard alloc then completing write
    drive(7, 0, 2'b00, 0, 0, 0, 0, 1'b1, 7);
    step("alloc7");
    drive(7, 7, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    #2;
    check("busy7_set", RW'(busy_vec[7]), 32'd1);
    check("rd_busy7", RW'(rd_busy[0]), 32'd1);
    step("busy7");
    drive(7, 0, 2'b10, 0, 0, 7, 32'd99, 1'b0, 0);
    step("wr7");
    drive(7, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    #2;
    check("busy7_clr", RW'(busy_vec[7]), 32'd0);
    check("rd7_99", rd_data[RW-1:0], 32'd99);
    step("rd7");

    // Collision on idx 3 with simultaneous alloc
    drive(3, 0, 2'b11, 3, 32'd11, 3, 32'd22, 1'b1, 3);
    #2;
    check("coll_bypass", rd_data[RW-1:0], 32'd22);
    step("coll3");
    drive(3, 3, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    #2;
    check("coll_data", rd_data[RW-1:0], 32'd22);
    check("coll_busy3", RW'(busy_vec[3]), 32'd1);
    step("rd3");

    // Mid-operation reset with a write and alloc in flight
    drive(5, 7, 2'b00, 0, 0, 0, 0, 1'b1, 7);
    step("pre_alloc7");
    drive(5, 7, 2'b11, 5, 32'hdead, 9, 32'hbeef, 1'b1, 9);
    #3;
    rst = 1'b0;
    model_clear();
    #1;
    check_outputs("midrst");
    check("midrst_busyvec", RW'(busy_vec), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(5, 9, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    step("post_rst");

    // Randomized traffic over a small index window to force collisions
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
